// File: rtl/time_preset_entry_pkg.sv
// Shared types and constants for the preset-entry front panel.
package time_preset_entry_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned DEB_CNT_W = 16;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef logic [0:0] state_t;
    localparam state_t ST_EDIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    // Modulo-10 BCD increment; anything at or above 9 wraps to 0.
    function automatic digit_t bcd_inc(input digit_t d);
        return (d >= digit_t'(9)) ? digit_t'(0) : d + digit_t'(1);
    endfunction

endpackage

// File: rtl/time_preset_entry_if.sv
// Key/done inputs and preset/control outputs of the preset-entry block.
interface time_preset_entry_if;
    import time_preset_entry_pkg::*;

    logic   key_sel_i;
    logic   key_inc_i;
    logic   key_start_i;
    logic   done_i;
    digit_t time_h_o;
    digit_t time_l_o;
    logic   load_o;
    logic   run_o;
    logic   edit_h_o;

    modport master (
        output key_sel_i, key_inc_i, key_start_i, done_i,
        input  time_h_o, time_l_o, load_o, run_o, edit_h_o
    );

    modport slave (
        input  key_sel_i, key_inc_i, key_start_i, done_i,
        output time_h_o, time_l_o, load_o, run_o, edit_h_o
    );

endinterface

// File: rtl/time_preset_entry_key_debounce.sv
// Raw push-button to single-cycle press event: 2-FF sync, debounce, rising-edge pulse.
module key_debounce
    import time_preset_entry_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic event_o
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

    logic                 sync1_q, sync2_q;
    logic                 level_q, level_d;
    logic                 level_prev_q;
    logic                 event_q;
    logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

    // Level flips only after DEB_CYCLES consecutive mismatching samples.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DEB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            event_q      <= 1'b0;
        end else begin
            sync1_q      <= key_i;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            event_q      <= level_q & ~level_prev_q;
        end
    end

    assign event_o = event_q;

endmodule

// File: rtl/time_preset_entry.sv
// Two-digit BCD preset editor with start/stop control for a countdown counter.
module time_preset_entry
    import time_preset_entry_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 20,
    parameter int unsigned INIT_H     = 6,
    parameter int unsigned INIT_L     = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    time_preset_entry_if.slave        bus
);

    localparam digit_t RST_H = digit_t'(INIT_H);
    localparam digit_t RST_L = digit_t'(INIT_L);

    logic   sel_ev, inc_ev, start_ev;
    state_t state_q, state_d;
    digit_t time_h_q, time_h_d;
    digit_t time_l_q, time_l_d;
    logic   edit_h_q, edit_h_d;
    logic   load_q, load_d;
    logic   run_q, run_d;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
        .clk_i(clk_i), .rst_i(rst_i), .key_i(bus.key_sel_i), .event_o(sel_ev)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk_i(clk_i), .rst_i(rst_i), .key_i(bus.key_inc_i), .event_o(inc_ev)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk_i(clk_i), .rst_i(rst_i), .key_i(bus.key_start_i), .event_o(start_ev)
    );

    // Increment uses the pre-toggle selection when sel and inc coincide.
    always_comb begin
        state_d  = state_q;
        time_h_d = time_h_q;
        time_l_d = time_l_q;
        edit_h_d = edit_h_q;
        load_d   = 1'b0;
        run_d    = run_q;
        if (state_q == ST_EDIT) begin
            if (sel_ev) begin
                edit_h_d = ~edit_h_q;
            end
            if (inc_ev) begin
                if (edit_h_q) begin
                    time_h_d = bcd_inc(time_h_q);
                end else begin
                    time_l_d = bcd_inc(time_l_q);
                end
            end
            if (start_ev && ((time_h_q != '0) || (time_l_q != '0))) begin
                state_d = ST_RUN;
                load_d  = 1'b1;
                run_d   = 1'b1;
            end
        end else begin
            if (start_ev || bus.done_i) begin
                state_d = ST_EDIT;
                run_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_EDIT;
            time_h_q <= RST_H;
            time_l_q <= RST_L;
            edit_h_q <= 1'b0;
            load_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            time_h_q <= time_h_d;
            time_l_q <= time_l_d;
            edit_h_q <= edit_h_d;
            load_q   <= load_d;
            run_q    <= run_d;
        end
    end

    assign bus.time_h_o = time_h_q;
    assign bus.time_l_o = time_l_q;
    assign bus.edit_h_o = edit_h_q;
    assign bus.load_o   = load_q;
    assign bus.run_o    = run_q;

endmodule

// File: tb/tb_time_preset_entry.sv
// Self-checking bench for time_preset_entry with a short debounce window.
module tb_time_preset_entry;

    localparam int unsigned DEB = 4;

    typedef struct {
        logic [2:0] keys;       // bit0 sel, bit1 inc, bit2 start
        bit         done_co;    // done=1 in the same cycle the start event lands
        bit         done_only;  // a lone done pulse, no key
        int         h, l, e, r, loads;
    } vec_t;

    typedef struct {
        int h, l, e, r, loads;
    } exp_t;

    logic clk;
    logic rst;
    time_preset_entry_if bus();

    time_preset_entry #(.DEB_CYCLES(DEB), .INIT_H(6), .INIT_L(0)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks   = 0;
    int   errors   = 0;
    int   load_cnt = 0;
    logic prev_run = 1'b0;
    logic prev_load = 1'b0;
    vec_t vecs[$];
    exp_t sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle, sample just after the edge and police the load pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.load_o === 1'b1) begin
            load_cnt++;
            check("load_only_first_run_cycle",
                  int'({bus.run_o, prev_run, prev_load}), 4);
        end
        prev_run  = bus.run_o;
        prev_load = bus.load_o;
    endtask

    task automatic press(input logic [2:0] keys, input bit done_co);
        bus.key_sel_i   = keys[0];
        bus.key_inc_i   = keys[1];
        bus.key_start_i = keys[2];
        repeat (7) tick();
        if (done_co) bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        repeat (2) tick();
        bus.key_sel_i   = 1'b0;
        bus.key_inc_i   = 1'b0;
        bus.key_start_i = 1'b0;
        repeat (10) tick();
    endtask

    task automatic add(input logic [2:0] keys, input bit dco, input bit donly,
                       input int h, input int l, input int e, input int r, input int ld);
        vec_t v;
        v.keys = keys; v.done_co = dco; v.done_only = donly;
        v.h = h; v.l = l; v.e = e; v.r = r; v.loads = ld;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input exp_t x);
        check({tag, "_time_h"}, int'(bus.time_h_o), x.h);
        check({tag, "_time_l"}, int'(bus.time_l_o), x.l);
        check({tag, "_edit_h"}, int'(bus.edit_h_o), x.e);
        check({tag, "_run"},    int'(bus.run_o),    x.r);
    endtask

    initial begin
        exp_t x;
        exp_t got;
        int   ld0;

        // units increments up to 9, then wrap to 0
        for (int i = 2; i <= 9; i++) add(3'b010, 0, 0, 6, i, 0, 0, 0);
        add(3'b010, 0, 0, 6, 0, 0, 0, 0);
        add(3'b100, 0, 0, 6, 0, 0, 1, 1);   // start with 60
        add(3'b000, 0, 1, 6, 0, 0, 0, 0);   // done stops run
        add(3'b100, 0, 0, 6, 0, 0, 1, 1);   // restart
        add(3'b010, 0, 0, 6, 0, 0, 1, 0);   // inc ignored in run
        add(3'b001, 0, 0, 6, 0, 0, 1, 0);   // sel ignored in run
        add(3'b100, 1, 0, 6, 0, 0, 0, 0);   // start + done together
        add(3'b001, 0, 0, 6, 0, 1, 0, 0);   // select tens
        add(3'b010, 0, 0, 7, 0, 1, 0, 0);
        add(3'b010, 0, 0, 8, 0, 1, 0, 0);
        add(3'b010, 0, 0, 9, 0, 1, 0, 0);
        add(3'b010, 0, 0, 0, 0, 1, 0, 0);   // tens wrap, no carry
        add(3'b100, 0, 0, 0, 0, 1, 0, 0);   // preset 00: start ignored
        add(3'b011, 0, 0, 1, 0, 0, 0, 0);   // sel+inc: tens gets the inc
        add(3'b100, 0, 0, 1, 0, 0, 1, 1);   // start with 10

        rst = 1'b1;
        bus.key_sel_i = 1'b0; bus.key_inc_i = 1'b0; bus.key_start_i = 1'b0; bus.done_i = 1'b0;
        repeat (3) tick();
        x = '{h: 6, l: 0, e: 0, r: 0, loads: 0};
        check_outputs("reset", x);
        check("reset_load", int'(bus.load_o), 0);
        rst = 1'b0;

        // Held key: event lands in cycle 7, TimeL updates on edge 8.
        bus.key_inc_i = 1'b1;
        repeat (7) tick();
        check("hold_before_event_time_l", int'(bus.time_l_o), 0);
        tick();
        check("hold_after_event_time_l", int'(bus.time_l_o), 1);
        repeat (2) tick();
        bus.key_inc_i = 1'b0;
        repeat (10) tick();
        check("hold_single_event_time_l", int'(bus.time_l_o), 1);
        check("hold_time_h", int'(bus.time_h_o), 6);

        // Glitches shorter than the debounce window are rejected.
        for (int w = 1; w <= 3; w++) begin
            bus.key_inc_i = 1'b1;
            repeat (w) tick();
            bus.key_inc_i = 1'b0;
            repeat (12) tick();
            check($sformatf("glitch%0d_time_l", w), int'(bus.time_l_o), 1);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            x = '{h: vecs[i].h, l: vecs[i].l, e: vecs[i].e, r: vecs[i].r, loads: vecs[i].loads};
            sb_q.push_back(x);
            ld0 = load_cnt;
            if (vecs[i].done_only) begin
                bus.done_i = 1'b1;
                tick();
                bus.done_i = 1'b0;
                repeat (3) tick();
            end else begin
                press(vecs[i].keys, vecs[i].done_co);
            end
            got = sb_q.pop_front();
            check_outputs($sformatf("vec%0d", i), got);
            check($sformatf("vec%0d_loads", i), load_cnt - ld0, got.loads);
        end

        // Asynchronous reset while running, sampled before any further edge.
        check("pre_reset_run", int'(bus.run_o), 1);
        #2;
        rst = 1'b1;
        #1;
        x = '{h: 6, l: 0, e: 0, r: 0, loads: 0};
        check_outputs("async_reset", x);
        check("async_reset_load", int'(bus.load_o), 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        check("post_reset_run", int'(bus.run_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_preset_entry.md
TIME_PRESET_ENTRY -- requirements
Module: time_preset_entry

Interface
REQ-001 Parameter DEB_CYCLES, default 20, is the number of consecutive stable clock cycles a key needs before it is accepted (range 2..65535).
REQ-002 Parameter INIT_H, default 6, is the reset value of the tens BCD digit (0..9).
REQ-003 Parameter INIT_L, default 0, is the reset value of the units BCD digit (0..9).
REQ-004 clock  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 key_sel  in  1  raw push-button, active-high, asynchronous to clock; selects which digit is edited.
REQ-007 key_inc  in  1  raw push-button; increments the selected digit.
REQ-008 key_start  in  1  raw push-button; start/stop.
REQ-009 done  in  1  countdown-finished level from the counter block, synchronous to clock.
REQ-010 TimeH  out  4  preset tens digit, BCD.
REQ-011 TimeL  out  4  preset units digit, BCD.
REQ-012 load  out  1  one-cycle pulse; the counter captures TimeH/TimeL.
REQ-013 run  out  1  level; the counter is enabled to count down.
REQ-014 edit_h  out  1  1 = tens digit selected, 0 = units digit selected.

Function
REQ-015 Each key SHALL pass through a 2-FF synchronizer and then a debounce counter; the debounced level toggles only after the synchronized input differs from it for DEB_CYCLES consecutive cycles, and any mismatch-free cycle clears the count.
REQ-016 A press event is a one-cycle pulse on the rising edge of a debounced level; with the raw key held high, the event is high in cycle 3+DEB_CYCLES counted from the first clock edge that samples it high.
REQ-017 FSM states: EDIT, RUN. Reset state is EDIT.
REQ-018 EDIT, sel event: toggle edit_h.
REQ-019 EDIT, inc event: the selected digit increments modulo 10 (9 -> 0); no carry into the other digit.
REQ-020 EDIT, sel and inc in the same cycle: the increment applies to the digit selected before the toggle.
REQ-021 EDIT, start event with TimeH=TimeL=0: ignored; the FSM stays in EDIT and no load is issued.
REQ-022 EDIT, start event with a nonzero preset: load=1 and run=1 in the next cycle; state becomes RUN.
REQ-023 RUN: sel and inc events are ignored; TimeH and TimeL stay constant.
REQ-024 RUN, start event or done=1: run=0 from the next cycle; state becomes EDIT; the preset is retained.
REQ-025 RUN, start event and done in the same cycle: a single transition to EDIT; no load is issued.
REQ-026 load SHALL never be high for two consecutive cycles, and SHALL be high only on the first cycle of run.
REQ-027 TimeH/TimeL SHALL always hold valid BCD (0..9).
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Reset SHALL force these values: TimeH=INIT_H, TimeL=INIT_L, load=0, run=0, edit_h=0, state EDIT.
REQ-030 Reset SHALL also clear the synchronizers, debounced levels and debounce counters to 0.
REQ-031 A key held through reset release generates one press event after the debounce delay in REQ-016.
REQ-032 Reset asserted in RUN SHALL take effect immediately, dropping run with no load pulse.

Structure
REQ-033 A shared package SHALL hold the FSM state typedef (EDIT, RUN) and the BCD digit width constant (4).
REQ-034 One sub-module, key_debounce (synchronizer, debounce counter and edge pulse), SHALL be instantiated once per key.

Verification
REQ-035 Verification SHALL cover these directed scenarios, with DEB_CYCLES=4:
- Reset, then hold key_inc high 10 cycles -> a single event in cycle 7; TimeL 0 -> 1; TimeH stays 6.
- Key_inc glitch 1-3 cycles wide -> no event; TimeL unchanged.
- Select units, 10 inc presses -> TimeL wraps 9 -> 0; TimeH unchanged.
- Preset 00, press start -> no load, run stays 0.
- Preset 60, press start -> load high exactly one cycle, coincident with run rising; then done=1 -> run=0 next cycle, preset still 60.
- In RUN, press inc/sel -> no change; start and done together -> run=0, no load.
- Assert reset mid-RUN -> all outputs at reset values asynchronously.
